acc_matmul_seq: RTL
===================

// Module: acc_matmul_seq
// PURPOSE
//  Sequential matrix-multiply engine. Responder end of the core_region accelerator start/operand interface.
//  Computes C = A x B for square MAT_SIZE x MAT_SIZE matrices, one multiply-accumulate (MAC) per clock.
//  Adds busy/done handshake; core_region drives start + operands and samples result on done.
//  Sits beside core_region in pulpino_top on clk_int/rstn_int.
// PARAMETERS
//  DAT_SIZE  8   operand element width, unsigned
//  MAT_SIZE  2   matrix dimension N (N>=1); N*N elements per operand
//  OUT_W     32  result element width, unsigned
// PORTS
//  clk      in   1              core clock (clk_int)
//  rst_n    in   1              reset, asynchronous, active-low
//  start_i  in   1              request; accepted only when busy_o==0
//  a_i      in   N*N*DAT_SIZE   operand A; elem(r,c) at [(r*N+c)*DAT_SIZE +: DAT_SIZE]
//  b_i      in   N*N*DAT_SIZE   operand B; same packing
//  busy_o   out  1              high from cycle after accept until done_o cycle (exclusive)
//  done_o   out  1              one-cycle pulse: out_o holds new result
//  out_o    out  N*N*OUT_W      result C; elem(r,c) at [(r*N+c)*OUT_W +: OUT_W]
// BEHAVIOUR
//  Reset: state IDLE, busy_o=0, done_o=0, out_o=0, all internal regs 0.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: on start_i, snapshot a_i/b_i into internal regs, zero i,j,k and acc; go to CALC.
//   CALC: each cycle acc_next = acc + A[i][k]*B[k][j], where acc is the running sum for element (i,j).
//    Product width is 2*DAT_SIZE, zero-extended to OUT_W.
//    k==N-1: write acc_next to work[i][j]; clear acc; advance j, then i (row-major).
//    Last MAC at i=j=k=N-1: go to DONE.
//   DONE: copy work into out_o; pulse done_o; busy_o=0; go to IDLE.
//  Latency: start accepted at cycle t -> CALC for cycles t+1..t+N^3 -> done_o at t+N^3+1.
//  out_o is stable between done pulses; it is updated only in the DONE cycle.
//  Operands may change after accept; the snapshot alone is used.
//  start_i while busy_o==1: ignored, not queued.
//  start_i in the DONE cycle: accepted (busy_o==0); next state CALC, done_o still pulses.
//  start_i held high: the engine re-runs back-to-back, one done_o every N^3+1 cycles.
//  Async reset mid-CALC: immediate return to reset state; partial result discarded; no done_o.
//  Arithmetic: overflow handling is set by ACC_SATURATE_EN (see CONFIGURATION).
//  Overflow cannot occur when OUT_W >= 2*DAT_SIZE + clog2(N).
// CONFIGURATION
//  `ACC_SATURATE_EN defined: each MAC add clamps to 2^OUT_W-1; once clamped, the element stays at max.
//  `ACC_SATURATE_EN undefined: MAC add wraps modulo 2^OUT_W; no extra logic.
//  All other behaviour and timing are identical with or without the macro.
// TESTING
//  1 Reset: after rst_n release, busy_o=0, done_o=0, out_o=0; no done_o without a start_i.
//  2 A=[[1,2],[3,4]], B=[[5,6],[7,8]], 1-cycle start -> done_o exactly 9 cycles later,
//    out_o=[[19,22],[43,50]]; busy_o high for 8 cycles.
//  3 A=I, B=[[9,8],[7,6]]; change a_i/b_i to 0 the cycle after start -> out_o=[[9,8],[7,6]] (snapshot).
//  4 A=B=all 255, OUT_W=16 -> 130050 per element exceeds 65535:
//    macro defined -> out_o elements 65535; macro undefined -> 64514.
//  5 start_i pulsed at cycles 3 and 5 after the first accept -> only one done_o; start_i in the
//    DONE cycle -> second run, done_o 9 cycles later.
//  6 rst_n asserted mid-CALC (cycle 4) -> busy_o=0, out_o=0 immediately; no done_o; a fresh start
//    gives the correct result.

Source files
------------

// File: rtl/acc_matmul_seq.sv
// rtl/acc_matmul_seq.sv - sequential N x N matrix multiply engine, one MAC per clock
// Optional macro: ACC_SATURATE_EN (clamp accumulation at 2^OUT_W-1 instead of wrapping)
module acc_matmul_seq #(
  parameter int DAT_SIZE = 8,
  parameter int MAT_SIZE = 2,
  parameter int OUT_W    = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_i,
  input  logic [MAT_SIZE*MAT_SIZE*DAT_SIZE-1:0] a_i,
  input  logic [MAT_SIZE*MAT_SIZE*DAT_SIZE-1:0] b_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [MAT_SIZE*MAT_SIZE*OUT_W-1:0]    out_o
);

  localparam int N  = MAT_SIZE;
  localparam int EW = N * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * DAT_SIZE;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [EW*DAT_SIZE-1:0] a_q, b_q;
  logic [EW*OUT_W-1:0]    work_q, work_fin, out_q;
  logic [IW-1:0]          i_q, j_q, k_q;
  logic [OUT_W-1:0]       acc_q, acc_next, prod_ext;
  logic [DAT_SIZE-1:0]    a_el, b_el;
  logic [PW-1:0]          prod;
  logic                   k_last, j_last, i_last, accept;

  assign k_last = (k_q == LAST);
  assign j_last = (j_q == LAST);
  assign i_last = (i_q == LAST);

  assign a_el     = a_q[(int'(i_q) * N + int'(k_q)) * DAT_SIZE +: DAT_SIZE];
  assign b_el     = b_q[(int'(k_q) * N + int'(j_q)) * DAT_SIZE +: DAT_SIZE];
  assign prod     = PW'(a_el) * PW'(b_el);
  assign prod_ext = OUT_W'(prod);

`ifdef ACC_SATURATE_EN
  logic [OUT_W:0] sum;
  assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};
  assign acc_next = sum[OUT_W] ? '1 : sum[OUT_W-1:0];
`else
  assign acc_next = acc_q + prod_ext;
`endif

  // The last element is still in flight on the final MAC, so merge it in for the result copy.
  always_comb begin
    work_fin = work_q;
    work_fin[(EW-1)*OUT_W +: OUT_W] = acc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = CALC;
        accept  = 1'b1;
      end
      CALC: if (k_last && j_last && i_last) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        if (start_i) begin
          state_d = CALC;
          accept  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      work_q <= '0;
      out_q  <= '0;
      acc_q  <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
    end else if (accept) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
    end else if (state_q == CALC) begin
      if (k_last) begin
        work_q[(int'(i_q) * N + int'(j_q)) * OUT_W +: OUT_W] <= acc_next;
        acc_q <= '0;
        k_q   <= '0;
        if (j_last) begin
          j_q <= '0;
          i_q <= i_last ? '0 : i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
        if (j_last && i_last) out_q <= work_fin;
      end else begin
        acc_q <= acc_next;
        k_q   <= k_q + 1'b1;
      end
    end
  end

  assign busy_o = (state_q == CALC);
  assign done_o = (state_q == DONE);
  assign out_o  = out_q;

endmodule
